// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared pipeline encodings for the fetch/decode/execute stages
package pipeline_pkg;

  localparam int REG_ADDR_WIDTH = 5;
  localparam logic [REG_ADDR_WIDTH-1:0] ZERO_REG = '0;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_e;

  // Instruction word driven into IF/ID on a flush, and the zeroed ID/EX control bundle.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
  } id_ex_ctrl_t;

  localparam id_ex_ctrl_t BUBBLE_CTRL = '0;

endpackage

// File: rtl/fetch_controller_if.sv
// rtl/fetch_controller_if.sv - hazard inputs and fetch-stage controls of the fetch controller
interface fetch_controller_if #(
  parameter int REG_ADDR_WIDTH    = pipeline_pkg::REG_ADDR_WIDTH,
  parameter int STALL_COUNT_WIDTH = 16
);
  logic                         idExMemRead;
  logic [REG_ADDR_WIDTH-1:0]    idExRt;
  logic [REG_ADDR_WIDTH-1:0]    ifIdRs;
  logic [REG_ADDR_WIDTH-1:0]    ifIdRt;
  logic                         exBranchTaken;
  logic [31:0]                  exBranchTarget;
  logic                         idHalt;
  logic                         resume;

  logic                         pcWrite;
  logic                         ifIdWrite;
  logic                         branch;
  logic [31:0]                  branchProgramCounter;
  logic                         ifIdFlush;
  logic                         idExBubble;
  logic                         halted;
  logic [STALL_COUNT_WIDTH-1:0] stallCount;

  modport master (
    input  idExMemRead, idExRt, ifIdRs, ifIdRt, exBranchTaken, exBranchTarget, idHalt, resume,
    output pcWrite, ifIdWrite, branch, branchProgramCounter, ifIdFlush, idExBubble, halted,
           stallCount
  );

  modport slave (
    output idExMemRead, idExRt, ifIdRs, ifIdRt, exBranchTaken, exBranchTarget, idHalt, resume,
    input  pcWrite, ifIdWrite, branch, branchProgramCounter, ifIdFlush, idExBubble, halted,
           stallCount
  );

endinterface

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use hazard term
module hazard_detect #(
  parameter int REG_ADDR_WIDTH = pipeline_pkg::REG_ADDR_WIDTH
) (
  input  logic                      idExMemRead,
  input  logic [REG_ADDR_WIDTH-1:0] idExRt,
  input  logic [REG_ADDR_WIDTH-1:0] ifIdRs,
  input  logic [REG_ADDR_WIDTH-1:0] ifIdRt,
  output logic                      load_use
);

  // Register 0 is hardwired, so a load targeting it never produces a dependency.
  assign load_use = idExMemRead && (idExRt != '0) && ((idExRt == ifIdRs) || (idExRt == ifIdRt));

endmodule

// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - fetch-stage sequencer: load-use stalls, branch flushes, halt/resume
module fetch_controller #(
  parameter int REG_ADDR_WIDTH    = pipeline_pkg::REG_ADDR_WIDTH,
  parameter int FLUSH_CYCLES      = 1,
  parameter int STALL_COUNT_WIDTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  fetch_controller_if.master fc
);
  import pipeline_pkg::*;

  localparam logic [1:0] FLUSH_RELOAD = 2'(FLUSH_CYCLES - 1);

  fetch_state_e                 state_q, state_d;
  logic [1:0]                   flush_cnt_q, flush_cnt_d;
  logic                         pc_write_q, pc_write_d;
  logic                         if_id_write_q, if_id_write_d;
  logic                         branch_q, branch_d;
  logic                         if_id_flush_q, if_id_flush_d;
  logic                         id_ex_bubble_q, id_ex_bubble_d;
  logic                         halted_q, halted_d;
  logic [31:0]                  branch_pc_q, branch_pc_d;
  logic [STALL_COUNT_WIDTH-1:0] stall_count_q, stall_count_d;
  logic                         load_use;

  hazard_detect #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_hazard (
    .idExMemRead (fc.idExMemRead),
    .idExRt      (fc.idExRt),
    .ifIdRs      (fc.ifIdRs),
    .ifIdRt      (fc.ifIdRt),
    .load_use    (load_use)
  );

  always_comb begin
    state_d        = state_q;
    flush_cnt_d    = flush_cnt_q;
    branch_pc_d    = branch_pc_q;
    pc_write_d     = 1'b1;
    if_id_write_d  = 1'b1;
    branch_d       = 1'b0;
    if_id_flush_d  = 1'b0;
    id_ex_bubble_d = 1'b0;
    halted_d       = 1'b0;
    stall_count_d  = (!pc_write_q && (stall_count_q != '1)) ? stall_count_q + 1'b1 : stall_count_q;

    if (state_q == ST_HALT) begin
      if (fc.resume) begin
        state_d = ST_RUN;
      end else begin
        pc_write_d    = 1'b0;
        if_id_write_d = 1'b0;
        halted_d      = 1'b1;
      end
    end else if (fc.exBranchTaken) begin
      // A taken branch overrides everything younger, including an in-progress flush.
      state_d        = ST_FLUSH;
      flush_cnt_d    = FLUSH_RELOAD;
      branch_pc_d    = fc.exBranchTarget;
      branch_d       = 1'b1;
      if_id_flush_d  = 1'b1;
      id_ex_bubble_d = 1'b1;
    end else if (state_q == ST_FLUSH) begin
      if (flush_cnt_q != 2'd0) begin
        flush_cnt_d    = flush_cnt_q - 2'd1;
        if_id_flush_d  = 1'b1;
        id_ex_bubble_d = 1'b1;
      end else begin
        state_d = ST_RUN;
      end
    end else if (load_use) begin
      state_d        = ST_STALL;
      pc_write_d     = 1'b0;
      if_id_write_d  = 1'b0;
      id_ex_bubble_d = 1'b1;
    end else if (fc.idHalt) begin
      state_d       = ST_HALT;
      pc_write_d    = 1'b0;
      if_id_write_d = 1'b0;
      halted_d      = 1'b1;
    end else begin
      state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_RUN;
      flush_cnt_q    <= 2'd0;
      pc_write_q     <= 1'b1;
      if_id_write_q  <= 1'b1;
      branch_q       <= 1'b0;
      if_id_flush_q  <= 1'b0;
      id_ex_bubble_q <= 1'b0;
      halted_q       <= 1'b0;
      branch_pc_q    <= 32'd0;
      stall_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      flush_cnt_q    <= flush_cnt_d;
      pc_write_q     <= pc_write_d;
      if_id_write_q  <= if_id_write_d;
      branch_q       <= branch_d;
      if_id_flush_q  <= if_id_flush_d;
      id_ex_bubble_q <= id_ex_bubble_d;
      halted_q       <= halted_d;
      branch_pc_q    <= branch_pc_d;
      stall_count_q  <= stall_count_d;
    end
  end

  assign fc.pcWrite              = pc_write_q;
  assign fc.ifIdWrite            = if_id_write_q;
  assign fc.branch               = branch_q;
  assign fc.branchProgramCounter = branch_pc_q;
  assign fc.ifIdFlush            = if_id_flush_q;
  assign fc.idExBubble           = id_ex_bubble_q;
  assign fc.halted               = halted_q;
  assign fc.stallCount           = stall_count_q;

endmodule

// File: tb/tb_fetch_controller.sv
// tb/tb_fetch_controller.sv - directed and randomized checks of fetch_controller against a cycle model
module tb_fetch_controller;

  localparam int FC  = 2;
  localparam int SCW = 4;
  localparam int SAT = (1 << SCW) - 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fetch_controller_if #(.REG_ADDR_WIDTH(5), .STALL_COUNT_WIDTH(SCW)) bus ();

  fetch_controller #(.REG_ADDR_WIDTH(5), .FLUSH_CYCLES(FC), .STALL_COUNT_WIDTH(SCW)) dut (
    .clk   (clk),
    .reset (reset),
    .fc    (bus.master)
  );

  int total = 0;
  int bad   = 0;

  // Expected outputs for the current cycle plus the model's own bookkeeping.
  bit          e_pc, e_ifw, e_br, e_fl, e_bub, e_hlt;
  logic [31:0] e_bpc;
  int          e_cnt;
  bit          m_halt;
  int          flush_left;

  bit          g_mr, g_bt, g_h, g_rsm;
  logic [4:0]  g_rt, g_rs, g_rtt;
  logic [31:0] g_tgt;

  task automatic set_out(input bit pc, input bit ifw, input bit fl, input bit bub, input bit hlt);
    e_pc = pc; e_ifw = ifw; e_fl = fl; e_bub = bub; e_hlt = hlt;
  endtask

  task automatic model_reset();
    set_out(1, 1, 0, 0, 0);
    e_br = 0; e_bpc = 32'd0; e_cnt = 0; m_halt = 0; flush_left = 0;
  endtask

  task automatic drive(input bit mr, input logic [4:0] rt, input logic [4:0] rs, input logic [4:0] rtt,
                       input bit bt, input logic [31:0] tgt, input bit h, input bit rsm);
    g_mr = mr; g_rt = rt; g_rs = rs; g_rtt = rtt; g_bt = bt; g_tgt = tgt; g_h = h; g_rsm = rsm;
    bus.idExMemRead    = mr;
    bus.idExRt         = rt;
    bus.ifIdRs         = rs;
    bus.ifIdRt         = rtt;
    bus.exBranchTaken  = bt;
    bus.exBranchTarget = tgt;
    bus.idHalt         = h;
    bus.resume         = rsm;
  endtask

  task automatic idle();
    drive(0, 5'd0, 5'd0, 5'd0, 0, 32'd0, 0, 0);
  endtask

  // Next-cycle expectation from the behavioural rules; flush_left counts flush cycles still owed.
  task automatic model_step();
    bit dep;
    dep = g_mr && (g_rt != 0) && (g_rt == g_rs || g_rt == g_rtt);
    if (!e_pc) e_cnt = (e_cnt >= SAT) ? SAT : e_cnt + 1;
    e_br = 0;
    if (m_halt) begin
      if (g_rsm) begin
        m_halt = 0;
        set_out(1, 1, 0, 0, 0);
      end
    end else if (g_bt) begin
      e_br = 1; e_bpc = g_tgt; flush_left = FC - 1;
      set_out(1, 1, 1, 1, 0);
    end else if (flush_left > 0) begin
      flush_left--;
      set_out(1, 1, 1, 1, 0);
    end else if (e_fl) begin
      set_out(1, 1, 0, 0, 0);
    end else if (dep) begin
      set_out(0, 0, 0, 1, 0);
    end else if (g_h) begin
      m_halt = 1;
      set_out(0, 0, 0, 0, 1);
    end else begin
      set_out(1, 1, 0, 0, 0);
    end
  endtask

  task automatic check_all(input string tag);
    logic [41:0] obs, exp;
    obs = {bus.pcWrite, bus.ifIdWrite, bus.branch, bus.ifIdFlush, bus.idExBubble, bus.halted,
           bus.branchProgramCounter, bus.stallCount};
    exp = {e_pc, e_ifw, e_br, e_fl, e_bub, e_hlt, e_bpc, 4'(e_cnt)};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic pulse_reset(input string tag);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    idle();
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) tick("idle");
    chk_val("idle_count", 32'(bus.stallCount), 32'd0);

    drive(1, 5'd5, 5'd5, 5'd0, 0, 32'd0, 0, 0);
    tick("loaduse");
    chk_val("loaduse_pcwrite", 32'(bus.pcWrite), 32'd0);
    chk_val("loaduse_bubble", 32'(bus.idExBubble), 32'd1);
    idle();
    tick("loaduse_after");
    chk_val("loaduse_resumed", 32'(bus.pcWrite), 32'd1);
    chk_val("loaduse_count", 32'(bus.stallCount), 32'd1);

    drive(1, 5'd0, 5'd0, 5'd0, 0, 32'd0, 0, 0);
    tick("r0_nostall");
    chk_val("r0_pcwrite", 32'(bus.pcWrite), 32'd1);
    idle();
    tick("r0_after");

    drive(0, 5'd0, 5'd0, 5'd0, 1, 32'h40, 0, 0);
    tick("branch_entry");
    chk_val("branch_pulse", 32'(bus.branch), 32'd1);
    chk_val("branch_target", bus.branchProgramCounter, 32'h40);
    idle();
    tick("branch_flush2");
    chk_val("branch_single", 32'(bus.branch), 32'd0);
    chk_val("branch_flush2", 32'(bus.ifIdFlush), 32'd1);
    tick("branch_done");
    chk_val("branch_run", 32'(bus.ifIdFlush), 32'd0);

    drive(1, 5'd5, 5'd5, 5'd0, 1, 32'h80, 1, 0);
    tick("coincide");
    chk_val("coincide_pc", 32'(bus.pcWrite), 32'd1);
    chk_val("coincide_halt", 32'(bus.halted), 32'd0);
    idle();
    tick("coincide_f2");
    tick("coincide_done");

    pulse_reset("reset_before_halt");
    drive(0, 5'd0, 5'd0, 5'd0, 0, 32'd0, 1, 1);
    tick("halt_entry");
    idle();
    for (int i = 0; i < 9; i++) tick("halt_hold");
    chk_val("halt_held", 32'(bus.halted), 32'd1);
    drive(0, 5'd0, 5'd0, 5'd0, 0, 32'd0, 0, 1);
    tick("resume");
    chk_val("halt_count", 32'(bus.stallCount), 32'd10);
    chk_val("resume_run", 32'(bus.pcWrite), 32'd1);

    drive(0, 5'd0, 5'd0, 5'd0, 0, 32'd0, 1, 0);
    tick("sat_entry");
    drive(1, 5'd3, 5'd3, 5'd3, 1, 32'hdead, 1, 0);
    for (int i = 0; i < 20; i++) tick("sat_hold");
    chk_val("saturate", 32'(bus.stallCount), 32'd15);
    drive(0, 5'd0, 5'd0, 5'd0, 0, 32'd0, 0, 1);
    tick("sat_resume");

    drive(0, 5'd0, 5'd0, 5'd0, 1, 32'h100, 0, 0);
    tick("flush_before_reset");
    idle();
    pulse_reset("reset_midflush");
    chk_val("reset_bpc", bus.branchProgramCounter, 32'd0);
    tick("after_reset");
    chk_val("no_redirect", 32'(bus.ifIdFlush), 32'd0);

    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0), $urandom,
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0));
      tick("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
